refill_return_buffer: RTL and testbench

//  Parametrised cache-refill return buffer between the bus read-return channel and the I/D-cache.

---
 rtl/refill_return_buffer.sv | 121 ++++++++++++
 tb/tb_refill_return_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/refill_return_buffer.sv
// Cache-refill return buffer: assembles one line from wrap-order
// bus beats, forwards arrived words to the pipeline, flags burst errors.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, first_idx    begin a refill at the critical word index
//   beat_valid/data/last  bus read-return channel, one word per beat
//   rd_idx -> rd_word, rd_hit   pipeline read port, no latency
//   line, word_mask     assembled line and per-word arrival flags
//   busy, done, err     FILL state, completion pulse, sticky length error
module refill_return_buffer #(
   parameter  int WORD_W     = 32,
   parameter  int LINE_WORDS = 4,
   localparam int IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [IDX_W-1:0]             first_idx,
   input  logic                         beat_valid,
   input  logic [WORD_W-1:0]            beat_data,
   input  logic                         beat_last,
   input  logic [IDX_W-1:0]             rd_idx,
   output logic [WORD_W-1:0]            rd_word,
   output logic                         rd_hit,
   output logic [WORD_W*LINE_WORDS-1:0] line,
   output logic [LINE_WORDS-1:0]        word_mask,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(LINE_WORDS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] mem [LINE_WORDS];
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  cnt;
   logic              accept;
   logic              full_cnt;
   logic              end_beat;

   // a start in the same cycle always wins, so its beat is dropped
   assign accept   = (state == FILL) && beat_valid && !start;
   assign full_cnt = (cnt == LAST_CNT);
   assign end_beat = accept && (full_cnt || beat_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = FILL;
      end else begin
         unique case (state)
            IDLE: state_nxt = IDLE;
            FILL: if (end_beat) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            mem[i] <= '0;
         end
         word_mask <= '0;
         ptr       <= '0;
         cnt       <= '0;
         err       <= 1'b0;
      end else if (start) begin
         // line data is kept; only arrival tracking restarts
         word_mask <= '0;
         ptr       <= first_idx;
         cnt       <= '0;
         err       <= 1'b0;
      end else if (accept) begin
         mem[ptr]       <= beat_data;
         word_mask[ptr] <= 1'b1;
         ptr            <= ptr + 1'b1;
         cnt            <= cnt + 1'b1;
         // early beat_last or a full burst without beat_last
         if (end_beat && (full_cnt != beat_last)) begin
            err <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
      assign line[g*WORD_W +: WORD_W] = mem[g];
   end

   // same-cycle beat to the requested slot is forwarded directly
   always_comb begin
      rd_word = mem[rd_idx];
      rd_hit  = word_mask[rd_idx];
      if (accept && (ptr == rd_idx)) begin
         rd_word = beat_data;
         rd_hit  = 1'b1;
      end
   end

   assign busy = (state == FILL);
   assign done = (state == DONE);

endmodule

// File: tb/tb_refill_return_buffer.sv
// Scoreboard bench for refill_return_buffer: stimulus predicts outputs
// from a line-level model, a negedge monitor compares them.
module tb_refill_return_buffer;
   localparam int W = 32;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [1:0]     first_idx;
   logic           beat_valid;
   logic [W-1:0]   beat_data;
   logic           beat_last;
   logic [1:0]     rd_idx;
   logic [W-1:0]   rd_word;
   logic           rd_hit;
   logic [W*N-1:0] line;
   logic [N-1:0]   word_mask;
   logic           busy;
   logic           done;
   logic           err;

   refill_return_buffer #(
      .WORD_W    (W),
      .LINE_WORDS(N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .first_idx (first_idx),
      .beat_valid(beat_valid),
      .beat_data (beat_data),
      .beat_last (beat_last),
      .rd_idx    (rd_idx),
      .rd_word   (rd_word),
      .rd_hit    (rd_hit),
      .line      (line),
      .word_mask (word_mask),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic           hit;
      logic [W-1:0]   word;
      logic [W*N-1:0] line;
      logic [N-1:0]   mask;
      logic           busy;
      logic           done;
      logic           err;
   } obs_t;

   obs_t           exp_q[$];
   logic [W*N-1:0] line_q[$];
   int             checks = 0;
   int             errors = 0;
   logic           mon_en = 1'b0;

   // model: refill is a list of received words placed at first+k mod N
   logic [W-1:0] m_line [N];
   logic [N-1:0] m_mask;
   logic         m_fill;
   logic         m_done;
   logic         m_err;
   int           m_first;
   int           m_k;

   function automatic void chk(string nm, logic [W*N-1:0] act,
                               logic [W*N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endfunction

   function automatic logic [W*N-1:0] m_pack();
      logic [W*N-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = m_line[i];
      return v;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < N; i++) m_line[i] = '0;
      m_mask  = '0;
      m_fill  = 1'b0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_first = 0;
      m_k     = 0;
   endfunction

   task automatic cyc(input logic r, input logic s, input int fi,
                      input logic bv, input logic [W-1:0] bd,
                      input logic bl, input int ri);
      obs_t e;
      int   pos;
      rst        = r;
      start      = s;
      first_idx  = fi[1:0];
      beat_valid = bv;
      beat_data  = bd;
      beat_last  = bl;
      rd_idx     = ri[1:0];
      pos        = (m_first + m_k) % N;
      e.busy     = m_fill;
      e.done     = m_done;
      e.err      = m_err;
      e.mask     = m_mask;
      e.line     = m_pack();
      if (m_fill && bv && !s && pos == ri) begin
         e.hit  = 1'b1;
         e.word = bd;
      end else begin
         e.hit  = m_mask[ri];
         e.word = m_line[ri];
      end
      exp_q.push_back(e);
      if (r) begin
         m_reset();
      end else if (s) begin
         m_mask  = '0;
         m_first = fi;
         m_k     = 0;
         m_err   = 1'b0;
         m_fill  = 1'b1;
         m_done  = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_fill && bv) begin
            m_line[pos] = bd;
            m_mask[pos] = 1'b1;
            m_k++;
            if (m_k == N || bl) begin
               m_fill = 1'b0;
               m_done = 1'b1;
               if ((m_k == N) != bl) m_err = 1'b1;
               line_q.push_back(m_pack());
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [W-1:0] d, input logic l,
                       input int ri);
      cyc(1'b0, 1'b0, 0, 1'b1, d, l, ri);
   endtask

   task automatic idle(input int ri);
      cyc(1'b0, 1'b0, 0, 1'b0, '0, 1'b0, ri);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            chk("obs_queue_empty", 1, 0);
         end else begin
            obs_t e;
            e = exp_q.pop_front();
            chk("rd_hit", rd_hit, e.hit);
            chk("rd_word", rd_word, e.word);
            chk("line", line, e.line);
            chk("word_mask", word_mask, e.mask);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            chk("err", err, e.err);
         end
         if (done === 1'b1) begin
            if (line_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_line", line, line_q.pop_front());
         end
      end
   end

   localparam logic [W-1:0] A = 32'haaaa_0001;
   localparam logic [W-1:0] B = 32'hbbbb_0002;
   localparam logic [W-1:0] C = 32'hcccc_0003;
   localparam logic [W-1:0] D = 32'hdddd_0004;

   initial begin
      logic [W*N-1:0] want;
      logic           bl;
      rst        = 1'b1;
      start      = 1'b0;
      first_idx  = '0;
      beat_valid = 1'b0;
      beat_data  = '0;
      beat_last  = 1'b0;
      rd_idx     = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      cyc(1'b1, 1'b0, 0, 1'b0, '0, 1'b0, 0);
      chk("reset_busy", busy, 0);
      chk("reset_mask", word_mask, 0);

      // stray beats before any start are ignored
      beat(A, 1'b1, 0);
      beat(B, 1'b0, 1);

      // back-to-back wrap fill from index 2
      cyc(1'b0, 1'b1, 2, 1'b0, '0, 1'b0, 0);
      beat(A, 1'b0, 2);
      beat(B, 1'b0, 2);
      beat(C, 1'b0, 1);
      beat(D, 1'b1, 1);
      want = {B, A, D, C};
      chk("t1_line", line, want);
      chk("t1_done", done, 1);
      chk("t1_err", err, 0);
      idle(3);

      // same refill with gaps
      cyc(1'b0, 1'b1, 2, 1'b0, '0, 1'b0, 2);
      beat(A, 1'b0, 2);
      idle(3);
      idle(2);
      beat(B, 1'b0, 3);
      beat(C, 1'b0, 0);
      idle(1);
      beat(D, 1'b1, 1);
      chk("t3_line", line, want);
      chk("t3_mask", word_mask, 4'b1111);
      idle(0);

      // early beat_last
      cyc(1'b0, 1'b1, 0, 1'b0, '0, 1'b0, 0);
      beat(C, 1'b0, 0);
      beat(D, 1'b1, 1);
      chk("t4_mask", word_mask, 4'b0011);
      chk("t4_err", err, 1);
      chk("t4_done", done, 1);
      cyc(1'b0, 1'b1, 1, 1'b0, '0, 1'b0, 0);
      chk("t4_err_clr", err, 0);

      // missing beat_last and reset mid fill
      beat(A, 1'b0, 1);
      beat(B, 1'b0, 2);
      cyc(1'b1, 1'b0, 0, 1'b0, '0, 1'b0, 1);
      chk("t5_line", line, '0);
      chk("t5_mask", word_mask, 0);
      chk("t5_busy", busy, 0);
      beat(C, 1'b0, 1);
      beat(D, 1'b1, 2);

      // start with a coincident beat, then start in the DONE cycle
      cyc(1'b0, 1'b1, 3, 1'b0, '0, 1'b0, 3);
      beat(A, 1'b0, 3);
      cyc(1'b0, 1'b1, 1, 1'b1, C, 1'b0, 1);
      beat(B, 1'b0, 1);
      beat(C, 1'b0, 2);
      beat(D, 1'b0, 3);
      beat(A, 1'b0, 0);
      cyc(1'b0, 1'b1, 0, 1'b1, B, 1'b1, 0);
      chk("t6_busy", busy, 1);
      chk("t6_done", done, 0);

      // missing beat_last
      beat(D, 1'b0, 0);
      beat(C, 1'b0, 1);
      beat(B, 1'b0, 2);
      beat(A, 1'b0, 3);
      chk("t7_err", err, 1);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) bl = 1'($urandom_range(0, 1));
         else bl = (m_fill && m_k == N - 1);
         cyc($urandom_range(0, 199) == 0,
             $urandom_range(0, 11) == 0,
             int'($urandom_range(0, N - 1)),
             $urandom_range(0, 99) < 65,
             $urandom, bl,
             int'($urandom_range(0, N - 1)));
      end
      repeat (3) idle(0);
      mon_en = 1'b0;
      chk("obs_left", exp_q.size(), 0);
      chk("done_left", line_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
